cvxif_addx_responder: RTL and testbench
=======================================

# cvxif_addx_responder

Coprocessor-side responder for the CV-X-IF port that carries the ADDX custom instruction. The core is the initiator and offloads instructions over this port. This block sits on the accelerator side of that port. It decodes offered instructions and accepts ADDX ones. It computes each result at issue, holds it in an in-order pending buffer until the core commits or kills the instruction, then returns committed results over a valid/ready result channel.

## Interface
Parameters:
- XLEN, 64, operand/result width (32 or 64)
- ID_WIDTH, 4, instruction id width (equals TRANS_ID_BITS)
- DEPTH, 4, pending-buffer entries (power of two, ≥2)

Ports:
- clk_i  in  1  clock; all state updates on its rising edge
- rst_i  in  1  reset, asynchronous, active-high
- issue_valid_i  in  1  core offers an instruction
- issue_ready_o  out  1  responder takes the offer this cycle
- issue_instr_i  in  32  instruction word
- issue_id_i  in  ID_WIDTH  instruction id
- issue_rs1_i, issue_rs2_i  in  XLEN  source operands
- issue_rs_valid_i  in  2  operand valid flags {rs2, rs1}
- issue_accept_o  out  1  instruction is ADDX and is taken
- issue_writeback_o  out  1  rd will be written; equals issue_accept_o
- commit_valid_i  in  1  commit/kill event
- commit_id_i  in  ID_WIDTH  id being committed
- commit_kill_i  in  1  1 = discard, 0 = retire
- result_valid_o  out  1  result available
- result_ready_i  in  1  core takes result
- result_id_o  out  ID_WIDTH  id of result
- result_data_o  out  XLEN  rd value
- result_rd_o  out  5  destination register
- result_we_o  out  1  write enable; equals result_valid_o

## Operation
- Decode requires opcode 7'b0001011 (custom-0) and funct7 7'b0000000.
  - funct3 000 is ADDX: rd = (rs1+rs2) mod 2^XLEN.
  - funct3 001 is ADDX.SAT: rd = min(rs1+rs2, 2^XLEN−1), computed with an XLEN+1-bit sum and its carry.
  - Any other encoding is not ADDX.
- Non-ADDX offer: issue_ready_o=1, issue_accept_o=0. Nothing is stored.
- ADDX offer: issue_ready_o=1 only when the buffer is not full and issue_rs_valid_i==2'b11. Otherwise issue_ready_o=0 and the core holds the offer.
- On an ADDX handshake, push {id, rd, data, committed=0, killed=0} at the tail.
- Commit event: find the valid entry whose id matches commit_id_i and set committed or killed. An event with no matching entry is ignored.
- A commit in the same cycle as the issue of the same id is applied to the entry being pushed.
- The head entry is popped:
  - if killed: popped in one cycle, no result is produced;
  - if committed: presented on the result channel and popped on result_valid_o & result_ready_i.
- Results leave in issue order, never reordered.
- result_* outputs are stable while result_valid_o=1 && result_ready_i=0.

## Timing
- Reset values: result_valid_o=0, result_we_o=0, result_id_o=0, result_data_o=0, result_rd_o=0. Buffer is empty, so issue_ready_o follows decode and has no stale state.
- Asserting rst_i mid-operation drops all pending and committed entries immediately. No result is emitted after reset for ids issued before it.
- issue_ready_o, issue_accept_o and issue_writeback_o are combinational from issue_* inputs and the full flag, with zero-cycle response.
- Result latency: result_valid_o rises at the cycle after max(issue edge, commit edge). The minimum is 1 cycle after issue when the commit arrives in the issue cycle.
- The result channel is registered from the buffer head and does not depend combinationally on issue_* or commit_*.
- Full: a pop and a push in the same cycle are both allowed. When full, issue_ready_o=0 for ADDX offers even if the head pops this cycle, so there is no ready-through-pop path.
- Pointers are log2(DEPTH) bits plus a wrap bit. They wrap modulo DEPTH.

## Structure
- Shared package `cvxif_addx_pkg` holds:
  - opcode, funct7 and funct3 localparams;
  - `addx_op_e` {ADDX, ADDX_SAT};
  - `addx_entry_t` {id, rd, data, committed, killed}.
- Sub-module `cvxif_addx_decode`: combinational decode plus ALU returning {is_addx, rd, data}.
- The buffer lives in the top module.

## Test plan
- ADDX with rs1=5, rs2=7, rd=x10, id=3, committed the same cycle → accept=1; result 1 cycle later with data=12, rd=10, id=3.
- ADDX.SAT with XLEN=64, rs1=2^64−2, rs2=5, committed 3 cycles later → data=2^64−1; result_valid_o rises at commit+1.
- Offer with opcode 0110011 → ready=1, accept=0, no result ever produced.
- Issue ids 1,2,3, kill id 2, commit 1 and 3 → results for ids 1 then 3 only, with result_ready_i held low 2 cycles and outputs stable.
- Issue DEPTH=4 entries without commit → 5th ADDX offer sees ready=0. After committing and draining the head, ready=1 with pointers wrapped correctly.
- Assert rst_i while 2 committed entries are pending → result_valid_o=0 immediately, no stale results afterwards.

Source files
------------

// File: rtl/cvxif_addx_pkg.sv
// Shared encodings and types for the ADDX coprocessor responder.
// The entry type is sized for the widest supported configuration; narrower instances zero-extend.
package cvxif_addx_pkg;

    localparam logic [6:0] OPCODE_CUSTOM0  = 7'b0001011;
    localparam logic [6:0] FUNCT7_ADDX     = 7'b0000000;
    localparam logic [2:0] FUNCT3_ADDX     = 3'b000;
    localparam logic [2:0] FUNCT3_ADDX_SAT = 3'b001;

    localparam int MAX_XLEN     = 64;
    localparam int MAX_ID_WIDTH = 8;

    typedef enum logic [0:0] {
        ADDX,
        ADDX_SAT
    } addx_op_e;

    typedef struct packed {
        logic [MAX_ID_WIDTH-1:0] id;
        logic [4:0]              rd;
        logic [MAX_XLEN-1:0]     data;
        logic                    committed;
        logic                    killed;
    } addx_entry_t;

endpackage

// File: rtl/cvxif_addx_responder_if.sv
// CV-X-IF issue/commit/result signals for the ADDX port; master is the core, slave the responder.
interface cvxif_addx_responder_if #(
    parameter int XLEN     = 64,
    parameter int ID_WIDTH = 4
);
    logic                issue_valid_i;
    logic                issue_ready_o;
    logic [31:0]         issue_instr_i;
    logic [ID_WIDTH-1:0] issue_id_i;
    logic [XLEN-1:0]     issue_rs1_i;
    logic [XLEN-1:0]     issue_rs2_i;
    logic [1:0]          issue_rs_valid_i;
    logic                issue_accept_o;
    logic                issue_writeback_o;
    logic                commit_valid_i;
    logic [ID_WIDTH-1:0] commit_id_i;
    logic                commit_kill_i;
    logic                result_valid_o;
    logic                result_ready_i;
    logic [ID_WIDTH-1:0] result_id_o;
    logic [XLEN-1:0]     result_data_o;
    logic [4:0]          result_rd_o;
    logic                result_we_o;

    modport master (
        output issue_valid_i, issue_instr_i, issue_id_i, issue_rs1_i, issue_rs2_i,
               issue_rs_valid_i, commit_valid_i, commit_id_i, commit_kill_i, result_ready_i,
        input  issue_ready_o, issue_accept_o, issue_writeback_o, result_valid_o,
               result_id_o, result_data_o, result_rd_o, result_we_o
    );

    modport slave (
        input  issue_valid_i, issue_instr_i, issue_id_i, issue_rs1_i, issue_rs2_i,
               issue_rs_valid_i, commit_valid_i, commit_id_i, commit_kill_i, result_ready_i,
        output issue_ready_o, issue_accept_o, issue_writeback_o, result_valid_o,
               result_id_o, result_data_o, result_rd_o, result_we_o
    );

endinterface

// File: rtl/cvxif_addx_decode.sv
// Combinational ADDX / ADDX.SAT decoder and adder.
module cvxif_addx_decode
    import cvxif_addx_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            is_addx,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] data
);

    addx_op_e        op;
    logic [XLEN:0]   sum;
    logic            unused_instr_bits;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        is_addx = 1'b0;
        op      = ADDX;
        if (instr[6:0] == OPCODE_CUSTOM0 && instr[31:25] == FUNCT7_ADDX) begin
            if (instr[14:12] == FUNCT3_ADDX) begin
                is_addx = 1'b1;
                op      = ADDX;
            end else if (instr[14:12] == FUNCT3_ADDX_SAT) begin
                is_addx = 1'b1;
                op      = ADDX_SAT;
            end
        end
    end

    // The extra sum bit is the carry that drives saturation.
    assign sum  = {1'b0, rs1} + {1'b0, rs2};
    assign data = (op == ADDX_SAT && sum[XLEN]) ? '1 : sum[XLEN-1:0];
    assign rd   = instr[11:7];

    // Register-source fields are carried by rs1/rs2 values, not decoded here.
    assign unused_instr_bits = ^instr[24:15];

endmodule

// File: rtl/cvxif_addx_responder.sv
// Accelerator-side CV-X-IF responder: accepts ADDX, buffers results in issue order until
// commit/kill, and returns committed results over the valid/ready result channel.
module cvxif_addx_responder
    import cvxif_addx_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int ID_WIDTH = 4,
    parameter int DEPTH    = 4
) (
    input logic                   clk_i,
    input logic                   rst_i,
    cvxif_addx_responder_if.slave bus
);

    localparam int             PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

    addx_entry_t      entries_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [PTR_W:0]   head_q;
    logic [PTR_W:0]   tail_q;
    logic [PTR_W-1:0] head_idx;
    logic [PTR_W-1:0] tail_idx;

    logic             is_addx;
    logic [4:0]       dec_rd;
    logic [XLEN-1:0]  dec_data;
    logic             full;
    logic             push;
    logic             pop;
    addx_entry_t      head;
    addx_entry_t      new_entry;

    cvxif_addx_decode #(.XLEN(XLEN)) u_decode (
        .instr   (bus.issue_instr_i),
        .rs1     (bus.issue_rs1_i),
        .rs2     (bus.issue_rs2_i),
        .is_addx (is_addx),
        .rd      (dec_rd),
        .data    (dec_data)
    );

    assign head_idx = head_q[PTR_W-1:0];
    assign tail_idx = tail_q[PTR_W-1:0];
    assign full     = (head_q[PTR_W] != tail_q[PTR_W]) && (head_idx == tail_idx);

    // Full blocks ADDX offers even when the head pops this cycle: no ready-through-pop path.
    assign bus.issue_ready_o     = !is_addx || (!full && bus.issue_rs_valid_i == 2'b11);
    assign bus.issue_accept_o    = is_addx && bus.issue_ready_o;
    assign bus.issue_writeback_o = bus.issue_accept_o;
    assign push                  = bus.issue_valid_i && bus.issue_accept_o;

    assign head = entries_q[head_idx];
    assign pop  = vld_q[head_idx] && (head.killed || (head.committed && bus.result_ready_i));

    assign bus.result_valid_o = vld_q[head_idx] && head.committed;
    assign bus.result_we_o    = bus.result_valid_o;
    assign bus.result_id_o    = bus.result_valid_o ? head.id[ID_WIDTH-1:0] : '0;
    assign bus.result_data_o  = bus.result_valid_o ? head.data[XLEN-1:0]   : '0;
    assign bus.result_rd_o    = bus.result_valid_o ? head.rd               : '0;

    always_comb begin
        new_entry      = '0;
        new_entry.id   = MAX_ID_WIDTH'(bus.issue_id_i);
        new_entry.rd   = dec_rd;
        new_entry.data = MAX_XLEN'(dec_data);
        // A commit for the id being issued this cycle lands on the pushed entry.
        if (bus.commit_valid_i && bus.commit_id_i == bus.issue_id_i) begin
            new_entry.committed = !bus.commit_kill_i;
            new_entry.killed    = bus.commit_kill_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q <= '0;
            tail_q <= '0;
            vld_q  <= '0;
        end else begin
            if (pop) begin
                vld_q[head_idx] <= 1'b0;
                head_q          <= head_q + PTR_ONE;
            end
            if (push) begin
                vld_q[tail_idx] <= 1'b1;
                tail_q          <= tail_q + PTR_ONE;
            end
        end
    end

    // NOTE: entry storage is not reset; vld_q qualifies every read, so stale contents are never seen.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push && tail_idx == PTR_W'(i)) begin
                entries_q[i] <= new_entry;
            end else if (bus.commit_valid_i && vld_q[i] &&
                         !entries_q[i].committed && !entries_q[i].killed &&
                         entries_q[i].id == MAX_ID_WIDTH'(bus.commit_id_i)) begin
                entries_q[i].committed <= !bus.commit_kill_i;
                entries_q[i].killed    <= bus.commit_kill_i;
            end
        end
    end

endmodule

// File: tb/tb_cvxif_addx_responder.sv
// Self-checking bench for cvxif_addx_responder: directed scenarios plus randomized traffic
// checked against a queue-based model of the pending instructions.
module tb_cvxif_addx_responder;

    localparam int XLEN     = 64;
    localparam int ID_WIDTH = 4;
    localparam int DEPTH    = 4;
    localparam logic [6:0] OPC    = 7'b0001011;
    localparam logic [6:0] OPC_OP = 7'b0110011;
    localparam logic [63:0] ALL1  = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cvxif_addx_responder_if #(.XLEN(XLEN), .ID_WIDTH(ID_WIDTH)) bus ();

    cvxif_addx_responder #(.XLEN(XLEN), .ID_WIDTH(ID_WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Model: pending instructions in issue order; st 0 = waiting, 1 = committed, 2 = killed.
    typedef struct {
        logic [3:0]  id;
        logic [4:0]  rd;
        logic [63:0] data;
        int          st;
    } pend_t;

    pend_t pend[$];
    int    seen[$];
    int    tests = 0;
    int    fails = 0;

    function automatic logic [31:0] enc(input logic [6:0] opcode, input logic [2:0] f3,
                                        input logic [4:0] rd);
        return {7'b0000000, 5'd2, 5'd1, f3, rd, opcode};
    endfunction

    function automatic bit m_is_addx(input logic [31:0] instr);
        return instr[6:0] == OPC && instr[31:25] == 7'd0 &&
               (instr[14:12] == 3'd0 || instr[14:12] == 3'd1);
    endfunction

    function automatic logic [63:0] m_result(input logic [31:0] instr, input logic [63:0] a,
                                             input logic [63:0] b);
        if (instr[14:12] == 3'd1 && a > ALL1 - b) return ALL1;
        return a + b;
    endfunction

    function automatic bit m_ready();
        if (!m_is_addx(bus.issue_instr_i)) return 1'b1;
        return pend.size() < DEPTH && bus.issue_rs_valid_i == 2'b11;
    endfunction

    function automatic bit m_res_valid();
        return pend.size() > 0 && pend[0].st == 1;
    endfunction

    function automatic bit id_pending(input logic [3:0] id);
        foreach (pend[i]) if (pend[i].id == id) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive_idle();
        bus.issue_valid_i    = 1'b0;
        bus.issue_instr_i    = '0;
        bus.issue_id_i       = '0;
        bus.issue_rs1_i      = '0;
        bus.issue_rs2_i      = '0;
        bus.issue_rs_valid_i = 2'b00;
        bus.commit_valid_i   = 1'b0;
        bus.commit_id_i      = '0;
        bus.commit_kill_i    = 1'b0;
    endtask

    task automatic drive_issue(input logic [31:0] instr, input logic [3:0] id,
                               input logic [63:0] a, input logic [63:0] b, input logic [1:0] rsv);
        bus.issue_valid_i    = 1'b1;
        bus.issue_instr_i    = instr;
        bus.issue_id_i       = id;
        bus.issue_rs1_i      = a;
        bus.issue_rs2_i      = b;
        bus.issue_rs_valid_i = rsv;
    endtask

    task automatic drive_commit(input logic [3:0] id, input logic kill);
        bus.commit_valid_i = 1'b1;
        bus.commit_id_i    = id;
        bus.commit_kill_i  = kill;
    endtask

    // Advance the model by one clock using the inputs currently driven, then cross the edge.
    task automatic tick();
        bit    do_pop;
        bit    do_push;
        pend_t e;
        do_pop  = pend.size() > 0 && (pend[0].st == 2 || (pend[0].st == 1 && bus.result_ready_i));
        do_push = bus.issue_valid_i && m_is_addx(bus.issue_instr_i) && m_ready();
        if (do_pop && pend[0].st == 1) seen.push_back(int'(pend[0].id));
        if (bus.commit_valid_i)
            foreach (pend[i])
                if (pend[i].st == 0 && pend[i].id == bus.commit_id_i) pend[i].st = bus.commit_kill_i ? 2 : 1;
        if (do_pop) void'(pend.pop_front());
        if (do_push) begin
            e.id   = bus.issue_id_i;
            e.rd   = bus.issue_instr_i[11:7];
            e.data = m_result(bus.issue_instr_i, bus.issue_rs1_i, bus.issue_rs2_i);
            e.st   = 0;
            if (bus.commit_valid_i && bus.commit_id_i == bus.issue_id_i) e.st = bus.commit_kill_i ? 2 : 1;
            pend.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive_idle();
        bus.result_ready_i = 1'b1;
        #1;
        tests++; if (bus.result_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", bus.result_valid_o); end
        tests++; if (bus.result_we_o !== 1'b0) begin fails++; $display("FAIL reset_we: got %b want 0", bus.result_we_o); end
        tests++; if (bus.result_id_o !== 4'd0 || bus.result_rd_o !== 5'd0) begin fails++; $display("FAIL reset_id_rd: got %h/%h want 0/0", bus.result_id_o, bus.result_rd_o); end
        tests++; if (bus.result_data_o !== 64'd0) begin fails++; $display("FAIL reset_data: got %h want 0", bus.result_data_o); end
        drive_issue(enc(OPC, 3'd0, 5'd1), 4'd0, 64'd1, 64'd1, 2'b11);
        #1;
        tests++; if (bus.issue_ready_o !== 1'b1 || bus.issue_accept_o !== 1'b1) begin fails++; $display("FAIL reset_ready_addx: got %b/%b want 1/1", bus.issue_ready_o, bus.issue_accept_o); end
        drive_idle();
        @(posedge clk);
        #1;
        rst = 1'b0;
        pend.delete();
        seen.delete();
        #1;
        tests++; if (bus.result_valid_o !== 1'b0) begin fails++; $display("FAIL reset_release_valid: got %b want 0", bus.result_valid_o); end
    endtask

    task automatic test_addx_basic();
        drive_idle();
        bus.result_ready_i = 1'b1;
        drive_issue(enc(OPC, 3'd0, 5'd10), 4'd3, 64'd5, 64'd7, 2'b11);
        drive_commit(4'd3, 1'b0);
        #1;
        tests++; if (bus.issue_accept_o !== 1'b1 || bus.issue_writeback_o !== 1'b1) begin fails++; $display("FAIL basic_accept: got %b/%b want 1/1", bus.issue_accept_o, bus.issue_writeback_o); end
        tests++; if (bus.result_valid_o !== 1'b0) begin fails++; $display("FAIL basic_no_early: got %b want 0", bus.result_valid_o); end
        tick();
        drive_idle();
        #1;
        tests++; if (bus.result_valid_o !== 1'b1 || bus.result_we_o !== 1'b1) begin fails++; $display("FAIL basic_valid: got %b/%b want 1/1", bus.result_valid_o, bus.result_we_o); end
        tests++; if (bus.result_data_o !== 64'd12 || bus.result_rd_o !== 5'd10 || bus.result_id_o !== 4'd3) begin fails++; $display("FAIL basic_result: got %0d/%0d/%0d want 12/10/3", bus.result_data_o, bus.result_rd_o, bus.result_id_o); end
        tick();
        #1;
        tests++; if (bus.result_valid_o !== 1'b0) begin fails++; $display("FAIL basic_drained: got %b want 0", bus.result_valid_o); end
    endtask

    task automatic test_sat();
        drive_idle();
        bus.result_ready_i = 1'b1;
        drive_issue(enc(OPC, 3'd1, 5'd7), 4'd5, ALL1 - 64'd1, 64'd5, 2'b11);
        #1;
        tests++; if (bus.issue_accept_o !== 1'b1) begin fails++; $display("FAIL sat_accept: got %b want 1", bus.issue_accept_o); end
        tick();
        for (int c = 1; c <= 3; c++) begin
            drive_idle();
            if (c == 3) drive_commit(4'd5, 1'b0);
            #1;
            tests++; if (bus.result_valid_o !== 1'b0) begin fails++; $display("FAIL sat_wait_c%0d: got %b want 0", c, bus.result_valid_o); end
            tick();
        end
        drive_idle();
        #1;
        tests++; if (bus.result_valid_o !== 1'b1 || bus.result_data_o !== ALL1) begin fails++; $display("FAIL sat_result: got %b/%h want 1/%h", bus.result_valid_o, bus.result_data_o, ALL1); end
        tick();
    endtask

    task automatic test_non_addx();
        drive_idle();
        bus.result_ready_i = 1'b1;
        drive_issue(enc(OPC_OP, 3'd0, 5'd4), 4'd6, 64'd1, 64'd2, 2'b11);
        #1;
        tests++; if (bus.issue_ready_o !== 1'b1 || bus.issue_accept_o !== 1'b0 || bus.issue_writeback_o !== 1'b0) begin fails++; $display("FAIL nonaddx_decode: got %b/%b/%b want 1/0/0", bus.issue_ready_o, bus.issue_accept_o, bus.issue_writeback_o); end
        tick();
        drive_idle();
        drive_commit(4'd6, 1'b0);
        for (int c = 0; c < 4; c++) begin
            #1;
            tests++; if (bus.result_valid_o !== 1'b0) begin fails++; $display("FAIL nonaddx_no_result_c%0d: got %b want 0", c, bus.result_valid_o); end
            tick();
            drive_idle();
        end
    endtask

    task automatic test_kill_order();
        logic [63:0] held_data;
        drive_idle();
        bus.result_ready_i = 1'b0;
        seen.delete();
        for (int k = 1; k <= 3; k++) begin
            drive_idle();
            drive_issue(enc(OPC, 3'(k % 2), 5'(k + 10)), 4'(k), {$urandom, $urandom}, {$urandom, $urandom}, 2'b11);
            #1;
            tests++; if (bus.issue_accept_o !== 1'b1) begin fails++; $display("FAIL kill_issue_%0d: got %b want 1", k, bus.issue_accept_o); end
            tick();
        end
        drive_idle();
        drive_commit(4'd1, 1'b0);
        tick();
        drive_idle();
        drive_commit(4'd2, 1'b1);
        #1;
        held_data = bus.result_data_o;
        tests++; if (bus.result_valid_o !== 1'b1 || bus.result_id_o !== 4'd1 || bus.result_data_o !== pend[0].data) begin fails++; $display("FAIL kill_head1: got %b/%0d/%h want 1/1/%h", bus.result_valid_o, bus.result_id_o, bus.result_data_o, pend[0].data); end
        tick();
        drive_idle();
        drive_commit(4'd3, 1'b0);
        #1;
        tests++; if (bus.result_valid_o !== 1'b1 || bus.result_id_o !== 4'd1 || bus.result_data_o !== held_data || bus.result_rd_o !== 5'd11) begin fails++; $display("FAIL kill_stable: got %b/%0d/%h/%0d want 1/1/%h/11", bus.result_valid_o, bus.result_id_o, bus.result_data_o, bus.result_rd_o, held_data); end
        tick();
        drive_idle();
        bus.result_ready_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            tests++; if (bus.result_valid_o !== m_res_valid()) begin fails++; $display("FAIL kill_drain_valid_c%0d: got %b want %b", c, bus.result_valid_o, m_res_valid()); end
            if (m_res_valid()) begin
                tests++; if (bus.result_id_o !== pend[0].id || bus.result_data_o !== pend[0].data) begin fails++; $display("FAIL kill_drain_data_c%0d: got %0d/%h want %0d/%h", c, bus.result_id_o, bus.result_data_o, pend[0].id, pend[0].data); end
            end
            tick();
        end
        tests++; if (seen.size() != 2 || seen[0] != 1 || seen[1] != 3) begin fails++; $display("FAIL kill_order: got %p want '{1, 3}", seen); end
    endtask

    task automatic test_full_wrap();
        logic [31:0] ins;
        drive_idle();
        bus.result_ready_i = 1'b1;
        seen.delete();
        for (int k = 0; k < DEPTH; k++) begin
            drive_idle();
            drive_issue(enc(OPC, 3'd0, 5'(k + 1)), 4'(k + 4), {$urandom, $urandom}, 64'(k), 2'b11);
            #1;
            tests++; if (bus.issue_ready_o !== 1'b1) begin fails++; $display("FAIL full_fill_%0d: got %b want 1", k, bus.issue_ready_o); end
            tick();
        end
        ins = enc(OPC, 3'd1, 5'd20);
        drive_idle();
        drive_issue(ins, 4'd8, 64'd100, 64'd23, 2'b11);
        #1;
        tests++; if (bus.issue_ready_o !== 1'b0 || bus.issue_accept_o !== 1'b0) begin fails++; $display("FAIL full_block: got %b/%b want 0/0", bus.issue_ready_o, bus.issue_accept_o); end
        tick();
        drive_commit(4'd4, 1'b0);
        tick();
        bus.commit_valid_i = 1'b0;
        #1;
        tests++; if (bus.result_valid_o !== 1'b1 || bus.result_id_o !== 4'd4 || bus.issue_ready_o !== 1'b0) begin fails++; $display("FAIL full_no_ready_through_pop: got %b/%0d/%b want 1/4/0", bus.result_valid_o, bus.result_id_o, bus.issue_ready_o); end
        tick();
        #1;
        tests++; if (bus.issue_ready_o !== 1'b1 || bus.issue_accept_o !== 1'b1) begin fails++; $display("FAIL full_reopen: got %b/%b want 1/1", bus.issue_ready_o, bus.issue_accept_o); end
        tick();
        for (int c = 0; c < 8; c++) begin
            drive_idle();
            if (c < 4) drive_commit(4'(c + 5), 1'b0);
            #1;
            tests++; if (bus.result_valid_o !== m_res_valid()) begin fails++; $display("FAIL wrap_valid_c%0d: got %b want %b", c, bus.result_valid_o, m_res_valid()); end
            if (m_res_valid()) begin
                tests++; if (bus.result_id_o !== pend[0].id || bus.result_data_o !== pend[0].data || bus.result_rd_o !== pend[0].rd) begin fails++; $display("FAIL wrap_data_c%0d: got %0d/%h/%0d want %0d/%h/%0d", c, bus.result_id_o, bus.result_data_o, bus.result_rd_o, pend[0].id, pend[0].data, pend[0].rd); end
            end
            tick();
        end
        tests++; if (seen.size() != 5 || seen[0] != 4 || seen[1] != 5 || seen[2] != 6 || seen[3] != 7 || seen[4] != 8) begin fails++; $display("FAIL wrap_order: got %p want '{4, 5, 6, 7, 8}", seen); end
    endtask

    task automatic test_reset_mid();
        drive_idle();
        bus.result_ready_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive_idle();
            drive_issue(enc(OPC, 3'd0, 5'd3), 4'(k + 9), 64'(k + 1), 64'd1, 2'b11);
            drive_commit(4'(k + 9), 1'b0);
            tick();
        end
        drive_idle();
        #1;
        tests++; if (bus.result_valid_o !== 1'b1 || bus.result_id_o !== 4'd9) begin fails++; $display("FAIL rstmid_before: got %b/%0d want 1/9", bus.result_valid_o, bus.result_id_o); end
        rst = 1'b1;
        #1;
        tests++; if (bus.result_valid_o !== 1'b0 || bus.result_data_o !== 64'd0 || bus.result_id_o !== 4'd0) begin fails++; $display("FAIL rstmid_async: got %b/%h/%0d want 0/0/0", bus.result_valid_o, bus.result_data_o, bus.result_id_o); end
        pend.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.result_ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            tests++; if (bus.result_valid_o !== 1'b0) begin fails++; $display("FAIL rstmid_stale_c%0d: got %b want 0", c, bus.result_valid_o); end
            tick();
        end
    endtask

    task automatic test_random();
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  nid;
        logic [2:0]  f3;
        int          kind;
        bit          exp_ready;
        for (int c = 0; c < 400; c++) begin
            drive_idle();
            bus.result_ready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0) begin
                do nid = 4'($urandom); while (id_pending(nid));
                kind = $urandom_range(0, 9);
                f3   = (kind < 4) ? 3'd0 : (kind < 8) ? 3'd1 : 3'd2;
                a    = {$urandom, $urandom};
                b    = {$urandom, $urandom};
                if ($urandom_range(0, 1) != 0) a = ALL1 - 64'($urandom_range(0, 20));
                if ($urandom_range(0, 2) == 0) b = 64'($urandom_range(0, 40));
                drive_issue(enc((kind == 9) ? OPC_OP : OPC, f3, 5'($urandom)), nid, a, b,
                            ($urandom_range(0, 5) == 0) ? 2'b01 : 2'b11);
            end
            if ($urandom_range(0, 1) != 0) begin
                if (pend.size() > 0 && $urandom_range(0, 3) != 0)
                    drive_commit(pend[$urandom_range(0, pend.size() - 1)].id, $urandom_range(0, 3) == 0);
                else if (bus.issue_valid_i && $urandom_range(0, 1) != 0)
                    drive_commit(bus.issue_id_i, $urandom_range(0, 3) == 0);
                else
                    drive_commit(4'($urandom), $urandom_range(0, 3) == 0);
            end
            #1;
            exp_ready = m_ready();
            tests++; if (bus.issue_ready_o !== exp_ready || bus.issue_accept_o !== (exp_ready && m_is_addx(bus.issue_instr_i))) begin fails++; $display("FAIL rand_issue_c%0d: got %b/%b want %b/%b", c, bus.issue_ready_o, bus.issue_accept_o, exp_ready, exp_ready && m_is_addx(bus.issue_instr_i)); end
            tests++; if (bus.result_valid_o !== m_res_valid()) begin fails++; $display("FAIL rand_valid_c%0d: got %b want %b", c, bus.result_valid_o, m_res_valid()); end
            if (m_res_valid()) begin
                tests++; if (bus.result_id_o !== pend[0].id || bus.result_data_o !== pend[0].data || bus.result_rd_o !== pend[0].rd) begin fails++; $display("FAIL rand_result_c%0d: got %0d/%h/%0d want %0d/%h/%0d", c, bus.result_id_o, bus.result_data_o, bus.result_rd_o, pend[0].id, pend[0].data, pend[0].rd); end
            end
            tick();
        end
    endtask

    initial begin
        drive_idle();
        bus.result_ready_i = 1'b1;
        test_reset();
        test_addx_basic();
        test_sat();
        test_non_addx();
        test_kill_order();
        test_full_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
